// File: rtl/cla64_arbiter_seq.sv
// Round-robin sequencer sharing one external carry-lookahead adder between NREQ requesters,
// with a per-requester stored carry for chained multi-word add/subtract.
module cla64_arbiter_seq #(
    parameter int DW   = 64,
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ-1:0]    req_sub,
    input  logic [NREQ-1:0]    req_chain,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_ovf,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      add_a,
    output logic [DW-1:0]      add_b,
    output logic               add_cin,
    input  logic [DW-1:0]      add_sum,
    input  logic               add_cout,
    output logic [31:0]        op_count
);

    localparam int NPAD = 2 ** IDW;

    logic [NREQ-1:0] carry_q_reg;
    logic [IDW-1:0]  rr_ptr_reg;
    logic [IDW-1:0]  rr_ptr_next;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            grant_any;
    logic            free;
    logic            ovf_next;
    logic [NREQ-1:0] grant_vec;

    // Per-requester views padded to 2**IDW entries so an IDW-bit index always fits exactly.
    logic [NPAD-1:0] valid_pad;
    logic [NPAD-1:0] sub_pad;
    logic [NPAD-1:0] chain_pad;
    logic [NPAD-1:0] carry_pad;
    logic [DW-1:0]   a_pad [NPAD];
    logic [DW-1:0]   b_pad [NPAD];

    generate
        for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
            if (gi < NREQ) begin : g_live
                assign valid_pad[gi] = req_valid[gi];
                assign sub_pad[gi]   = req_sub[gi];
                assign chain_pad[gi] = req_chain[gi];
                assign carry_pad[gi] = carry_q_reg[gi];
                assign a_pad[gi]     = req_a[gi*DW +: DW];
                assign b_pad[gi]     = req_b[gi*DW +: DW];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign sub_pad[gi]   = 1'b0;
                assign chain_pad[gi] = 1'b0;
                assign carry_pad[gi] = 1'b0;
                assign a_pad[gi]     = '0;
                assign b_pad[gi]     = '0;
            end
        end

        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign grant_vec[gi] = grant_any && (grant_idx == IDW'(gi));
        end
    endgenerate

    assign req_ready = grant_vec;
    assign free      = !rsp_valid || rsp_ready;

    // Scan the rotated order from the far end so the candidate nearest rr_ptr wins last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (free) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                cand = IDW'((int'(rr_ptr_reg) + k) % NREQ);
                if (valid_pad[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // Subtract is A + ~B + 1; a chained word replaces that 1 with the stored not-borrow.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant_any) begin
            add_a   = a_pad[grant_idx];
            add_b   = sub_pad[grant_idx] ? ~b_pad[grant_idx] : b_pad[grant_idx];
            add_cin = chain_pad[grant_idx] ? carry_pad[grant_idx] : sub_pad[grant_idx];
        end
    end

    assign ovf_next = (add_a[DW-1] == add_b[DW-1]) && (add_sum[DW-1] != add_a[DW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_id     <= '0;
            rr_ptr_reg <= '0;
            op_count   <= '0;
        end else if (grant_any) begin
            rsp_valid  <= 1'b1;
            rsp_sum    <= add_sum;
            rsp_cout   <= add_cout;
            rsp_ovf    <= ovf_next;
            rsp_id     <= grant_idx;
            rr_ptr_reg <= rr_ptr_next;
            op_count   <= op_count + 32'd1;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q_reg <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_vec[i]) carry_q_reg[i] <= add_cout;
            end
        end
    end

endmodule

// File: tb/tb_cla64_arbiter_seq.sv
// Bench for cla64_arbiter_seq: directed scenarios plus random traffic checked against
// a wide-arithmetic reference model of arbitration, carries and the response register.
module tb_cla64_arbiter_seq;

    localparam int DW   = 64;
    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_sub;
    logic [NREQ-1:0]    req_chain;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DW-1:0]      rsp_sum;
    logic               rsp_cout;
    logic               rsp_ovf;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      add_a;
    logic [DW-1:0]      add_b;
    logic               add_cin;
    logic [DW-1:0]      add_sum;
    logic               add_cout;
    logic [31:0]        op_count;

    always #5 clk = ~clk;

    // External adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};

    cla64_arbiter_seq #(.DW(DW), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_chain(req_chain),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .op_count(op_count)
    );

    // Reference model state
    bit          m_valid;
    logic [63:0] m_sum;
    bit          m_cout;
    bit          m_ovf;
    int          m_id;
    bit          m_carry [NREQ];
    int          m_rr;
    int unsigned m_count;
    int          last_g;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_id = 0;
        m_rr = 0; m_count = 0;
        for (int i = 0; i < NREQ; i++) m_carry[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input bit sub, input bit chain);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_sub[i]        = sub;
        req_chain[i]      = chain;
        req_valid[i]      = 1'b1;
    endtask

    task automatic rand_req(input int i);
        logic [63:0] a;
        logic [63:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: a = 64'hFFFF_FFFF_FFFF_FFFF;
            1: a = 64'h7FFF_FFFF_FFFF_FFFF;
            default: ;
        endcase
        set_req(i, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Inputs are already driven; check the grant mid-cycle, then the registered response.
    // keep=1 re-arms the granted requester with new random operands, otherwise it drops valid.
    task automatic do_cycle(input bit keep);
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_ready;
        logic [64:0]     full;
        logic [63:0]     a;
        logic [63:0]     b;
        @(negedge clk);
        g = -1;
        if (!m_valid || rsp_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (g >= 0) begin
            a = req_a[g*DW +: DW];
            b = req_b[g*DW +: DW];
            if (!req_sub[g]) begin
                full  = {1'b0, a} + {1'b0, b} + 65'(req_chain[g] ? m_carry[g] : 1'b0);
                m_cout = full[64];
                m_ovf  = (a[63] == b[63]) && (full[63] != a[63]);
            end else begin
                full  = {1'b0, a} - {1'b0, b} - 65'(req_chain[g] ? !m_carry[g] : 1'b0);
                m_cout = !full[64];
                m_ovf  = (a[63] != b[63]) && (full[63] != a[63]);
            end
            m_sum      = full[63:0];
            m_id       = g;
            m_valid    = 1'b1;
            m_carry[g] = m_cout;
            m_rr       = (g + 1) % NREQ;
            m_count++;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        chk("rsp_sum",   rsp_sum, m_sum);
        chk("rsp_cout",  64'(rsp_cout), 64'(m_cout));
        chk("rsp_ovf",   64'(rsp_ovf), 64'(m_ovf));
        chk("rsp_id",    64'(rsp_id), 64'(m_id));
        chk("op_count",  64'(op_count), 64'(m_count));
        last_g = g;
        if (g >= 0) begin
            if (keep) rand_req(g);
            else req_valid[g] = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        req_chain = '0;
        rsp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_sum",   rsp_sum, 64'd0);
        chk("reset_rsp_id",    64'(rsp_id), 64'd0);
        chk("reset_op_count",  64'(op_count), 64'd0);
        rst_n = 1'b1;

        // Single add wrapping to zero
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        do_cycle(1'b0);
        chk("add_sum_const",  rsp_sum, 64'h0);
        chk("add_cout_const", 64'(rsp_cout), 64'd1);
        chk("add_id_const",   64'(rsp_id), 64'd0);
        chk("add_cnt_const",  64'(op_count), 64'd1);

        // 128-bit chained add on requester 1
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        do_cycle(1'b0);
        chk("c128_lo_sum", rsp_sum, 64'h0);
        set_req(1, 64'h1, 64'h2, 1'b0, 1'b1);
        do_cycle(1'b0);
        chk("c128_hi_sum",  rsp_sum, 64'h4);
        chk("c128_hi_cout", 64'(rsp_cout), 64'd0);

        // 128-bit subtract with borrow on requester 0
        set_req(0, 64'h0, 64'h1, 1'b1, 1'b0);
        do_cycle(1'b0);
        chk("sub_lo_sum",  rsp_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub_lo_cout", 64'(rsp_cout), 64'd0);
        set_req(0, 64'h5, 64'h2, 1'b1, 1'b1);
        do_cycle(1'b0);
        chk("sub_hi_sum",  rsp_sum, 64'h2);
        chk("sub_hi_cout", 64'(rsp_cout), 64'd1);

        // Signed overflow
        set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        do_cycle(1'b0);
        chk("ovf_flag", 64'(rsp_ovf), 64'd1);
        chk("ovf_sum",  rsp_sum, 64'h8000_0000_0000_0000);

        // Round-robin with both requesters continuously valid
        rand_req(0);
        rand_req(1);
        do_cycle(1'b1);
        for (int n = 0; n < 5; n++) begin
            int prev;
            prev = last_g;
            do_cycle(1'b1);
            chk("rr_alternate", 64'(last_g), 64'((prev + 1) % NREQ));
        end

        // Backpressure: response held, no grants, then consume and accept on one edge
        rsp_ready = 1'b0;
        repeat (3) do_cycle(1'b1);
        rsp_ready = 1'b1;
        do_cycle(1'b1);
        chk("bp_accept", 64'(last_g >= 0), 64'd1);
        req_valid = '0;
        do_cycle(1'b0);

        // Reset while a response is pending and carry_q[1]=1
        rsp_ready = 1'b0;
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        do_cycle(1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_count", 64'(op_count), 64'd0);
        model_reset();
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 64'h5, 64'h6, 1'b0, 1'b1);
        do_cycle(1'b0);
        chk("post_rst_chain", rsp_sum, 64'd11);

        // Random traffic; a waiting requester holds its request until accepted
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) rand_req(i);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            do_cycle(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
